rv32m_muldiv_seq: RTL
=====================

RV32M_MULDIV_SEQ -- requirements
Module: rv32m_muldiv_seq

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: rs1  input  XLEN  operand A (multiplicand / dividend).
REQ-007 Port: rs2  input  XLEN  operand B (multiplier / divisor).
REQ-008 Port: flush  input  1  abort current operation.
REQ-009 Port: busy  output  1  high while an accepted operation is in progress.
REQ-010 Port: stall  output  1  combinational (start & IDLE) | busy; freezes the core PC.
REQ-011 Port: done  output  1  one-cycle pulse; result valid.
REQ-012 Port: result  output  XLEN  registered result, held until the next accepted start.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; busy = (state != IDLE) & (state != DONE).
REQ-014 IDLE: start=1 SHALL latch op, rs1, rs2, the operand signs and magnitudes; next state CALC, or DONE for special cases (REQ-020, REQ-021).
REQ-015 CALC SHALL run exactly 32 iterations from a 6-bit counter: radix-2 shift-add for multiply (64-bit product of magnitudes) and restoring shift-subtract for divide (quotient, remainder).
REQ-016 FIX (1 cycle) SHALL apply the sign correction and select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
REQ-017 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-018 Sign rules: product negated iff the operand signs differ; quotient negated iff the signs differ; remainder takes the sign of the dividend (truncating division).
REQ-019 Latency: start in cycle N -> CALC in N+1..N+32, FIX in N+33, DONE (done=1, result valid) in N+34; DONE -> IDLE next cycle.
REQ-020 Divide by zero (rs2=0, op 1xx) SHALL skip CALC: DONE in N+1; quotient = all ones; remainder = rs1.
REQ-021 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) SHALL skip CALC: DONE in N+1; DIV = 0x80000000; REM = 0.
REQ-022 start while busy or in DONE SHALL be ignored, and the latched operands SHALL NOT change.
REQ-023 A new start SHALL be accepted in the cycle after DONE, i.e. back-to-back operations are separated by one IDLE cycle.
REQ-024 flush in any state SHALL force IDLE on the next edge; no done for the aborted operation; result unchanged. flush has priority over start in the same cycle.
REQ-025 result SHALL be written only in the transition into DONE.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, counter=0, busy=0, done=0, result=0, and clear all internal registers, including when asserted mid-operation.
REQ-027 After rst_n deasserts, the first start SHALL be accepted normally with the REQ-019 latency.

Verification
REQ-028 MUL rs1=7, rs2=0xFFFFFFFD (-3), start in cycle N -> done=1 in cycle N+34 only, result=0xFFFFFFEB; busy high in N+1..N+33.
REQ-029 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF, done in N+1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done in N+1; REM with the same operands -> 0.
REQ-032 Start MUL in N, flush in N+10 -> busy=0 in N+11, no done pulse, result keeps its prior value; a start in N+11 completes normally at N+45.
REQ-033 rst_n pulsed low in N+20 of a DIV -> busy, done and result read 0 asynchronously; a start while busy in N+5 with new operands -> the first operation's result is unaffected.

Source files
------------

// File: rtl/rv32m_muldiv_seq_if.sv
// rv32m_muldiv_seq_if: request/response bundle between the core and the sequential RV32M unit
interface rv32m_muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, flush, op, rs1, rs2, input busy, stall, done, result);
  modport slave(input start, flush, op, rs1, rs2, output busy, stall, done, result);
endinterface

// File: rtl/rv32m_muldiv_seq.sv
// rv32m_muldiv_seq: 32-iteration shift-add multiplier / restoring divider for RV32M
module rv32m_muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst_n,
  rv32m_muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              signed_a, signed_b, sa, sb, div_zero, div_ovf, ge;
  logic [XLEN-1:0]   a_mag, b_mag, quo_s, rem_s, fix_res;
  logic [XLEN:0]     msum, dsh, ddiff;
  logic [2*XLEN-1:0] prod_s;
  // MULHU/DIVU/REMU are fully unsigned; MULHSU only keeps rs1 signed
  assign signed_a = !(bus.op == 3'b011 || bus.op == 3'b101 || bus.op == 3'b111);
  assign signed_b = signed_a && bus.op != 3'b010;
  assign sa       = signed_a & bus.rs1[XLEN-1];
  assign sb       = signed_b & bus.rs2[XLEN-1];
  assign a_mag    = sa ? -bus.rs1 : bus.rs1;
  assign b_mag    = sb ? -bus.rs2 : bus.rs2;
  assign div_zero = bus.op[2] && bus.rs2 == '0;
  assign div_ovf  = bus.op[2] && !bus.op[0] && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2 == '1;
  assign msum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign dsh      = {hi_q, lo_q[XLEN-1]};
  assign ddiff    = dsh - {1'b0, b_q};
  assign ge       = !ddiff[XLEN];
  assign prod_s   = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo_s    = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rem_s    = sa_q ? -hi_q : hi_q;
  assign fix_res  = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                  : (op_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (bus.flush)
      state_d = IDLE;
    else if (state_q == IDLE) begin
      if (bus.start) begin
        op_d    = bus.op;
        a_d     = a_mag;
        b_d     = b_mag;
        sa_d    = sa;
        sb_d    = sb;
        cnt_d   = '0;
        hi_d    = '0;
        lo_d    = bus.op[2] ? a_mag : b_mag;
        state_d = (div_zero || div_ovf) ? DONE : CALC;
        if (div_zero)
          result_d = bus.op[1] ? bus.rs1 : '1;
        else if (div_ovf)
          result_d = bus.op[1] ? '0 : bus.rs1;
      end
    end else if (state_q == CALC) begin
      // hi/lo hold {product} for multiply, {remainder, dividend->quotient} for divide
      hi_d    = op_q[2] ? (ge ? ddiff[XLEN-1:0] : dsh[XLEN-1:0]) : msum[XLEN:1];
      lo_d    = op_q[2] ? {lo_q[XLEN-2:0], ge} : {msum[0], lo_q[XLEN-1:1]};
      cnt_d   = cnt_q + 6'd1;
      state_d = cnt_q == 6'd31 ? FIX : CALC;
    end else if (state_q == FIX) begin
      result_d = fix_res;
      state_d  = DONE;
    end else
      state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end
  assign bus.busy   = state_q != IDLE && state_q != DONE;
  assign bus.done   = state_q == DONE;
  assign bus.stall  = (bus.start && state_q == IDLE) || bus.busy;
  assign bus.result = result_q;
endmodule
